// File: rtl/riscv_run_monitor.sv
// Run controller for the 16-bit RISC-V core: sequences core reset, counts cycles and
// retired instructions, and ends the run on a tohost store, a PC self-loop or a timeout.
module riscv_run_monitor #(
  parameter int                XLEN        = 16,
  parameter int                ADDR_W      = 16,
  parameter int                RST_CYCLES  = 2,
  parameter int                MAX_CYCLES  = 52,
  parameter int                HALT_CYCLES = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 16'hFFFE,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              retire_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  output logic              core_rst_o,
  output logic              running_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [XLEN-1:0]   exit_code_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  instret_cnt_o
);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SCW = $clog2(HALT_CYCLES + 1);

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0]   HALT_N   = SCW'(HALT_CYCLES);
  localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_CYCLES);

  // All architectural state in one record so rst and restart share one reset image.
  typedef struct packed {
    logic [1:0]        state;
    logic [RCW-1:0]    rst_cnt;
    logic              core_rst;
    logic              running;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [XLEN-1:0]   exit_code;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instret_cnt;
    logic [SCW-1:0]    stall_cnt;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid;
  } mon_t;

  localparam mon_t MON_RST = '{state: S_RST, core_rst: 1'b1, default: '0};

  mon_t r;

  logic [CNT_W-1:0] cyc_nxt, ir_nxt;
  logic [SCW-1:0]   stall_nxt;
  logic             pc_same, halt_evt, tohost_evt, timeout_evt;

  assign cyc_nxt     = (&r.cycle_cnt) ? r.cycle_cnt : r.cycle_cnt + 1'b1;
  assign ir_nxt      = (retire_i && !(&r.instret_cnt)) ? r.instret_cnt + 1'b1 : r.instret_cnt;
  assign pc_same     = r.pc_valid && (pc_i == r.pc_q);
  assign stall_nxt   = pc_same ? r.stall_cnt + 1'b1 : '0;
  assign halt_evt    = pc_same && (stall_nxt == HALT_N);
  assign tohost_evt  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
  assign timeout_evt = (MAX_CYCLES != 0) && (cyc_nxt == MAX_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= MON_RST;
    end else if (restart_i) begin
      r <= MON_RST;
    end else begin
      case (r.state)
        S_RST: begin
          r.rst_cnt <= r.rst_cnt + 1'b1;
          if (r.rst_cnt == RST_LAST) begin
            r.state    <= S_RUN;
            r.core_rst <= 1'b0;
            r.running  <= 1'b1;
          end
        end
        S_RUN: begin
          r.cycle_cnt   <= cyc_nxt;
          r.instret_cnt <= ir_nxt;
          r.pc_q        <= pc_i;
          r.pc_valid    <= 1'b1;
          r.stall_cnt   <= stall_nxt;
          // tohost outranks halt, halt outranks timeout
          if (tohost_evt) begin
            r.exit_code <= mem_wdata_i;
            r.pass      <= (mem_wdata_i == XLEN'(1));
          end else if (halt_evt) begin
            r.pass      <= 1'b1;
          end else if (timeout_evt) begin
            r.timeout   <= 1'b1;
          end
          if (tohost_evt || halt_evt || timeout_evt) begin
            r.state    <= S_DONE;
            r.core_rst <= 1'b1;
            r.running  <= 1'b0;
            r.done     <= 1'b1;
          end
        end
        default: ; // S_DONE: everything frozen until rst/restart
      endcase
    end
  end

  assign core_rst_o    = r.core_rst;
  assign running_o     = r.running;
  assign done_o        = r.done;
  assign pass_o        = r.pass;
  assign timeout_o     = r.timeout;
  assign exit_code_o   = r.exit_code;
  assign cycle_cnt_o   = r.cycle_cnt;
  assign instret_cnt_o = r.instret_cnt;
endmodule

// File: tb/tb_riscv_run_monitor.sv
// Bench for riscv_run_monitor: run outcomes go through a scoreboard checked when done_o rises;
// sequencing, hold and reset behaviour are checked inline in each scenario task.
module tb_riscv_run_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, restart, retire, we;
  logic [15:0] pc, addr, wdata;
  logic        core_rst, running, done, pass, tmo;
  logic [15:0] exitc;
  logic [31:0] cyc, ir;

  logic        restart2, retire2, we2;
  logic [15:0] pc2, addr2, wdata2;
  logic        core_rst2, running2, done2, pass2, tmo2;
  logic [15:0] exitc2;
  logic [31:0] cyc2, ir2;

  riscv_run_monitor dut (
    .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc), .retire_i(retire),
    .mem_we_i(we), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .core_rst_o(core_rst), .running_o(running), .done_o(done), .pass_o(pass),
    .timeout_o(tmo), .exit_code_o(exitc), .cycle_cnt_o(cyc), .instret_cnt_o(ir)
  );

  riscv_run_monitor #(.MAX_CYCLES(0)) dut_nt (
    .clk(clk), .rst(rst), .restart_i(restart2), .pc_i(pc2), .retire_i(retire2),
    .mem_we_i(we2), .mem_addr_i(addr2), .mem_wdata_i(wdata2),
    .core_rst_o(core_rst2), .running_o(running2), .done_o(done2), .pass_o(pass2),
    .timeout_o(tmo2), .exit_code_o(exitc2), .cycle_cnt_o(cyc2), .instret_cnt_o(ir2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ps;
    logic        to;
    logic [15:0] ex;
    logic [31:0] ir;
    logic [31:0] cy;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outcome scoreboard: every rising done_o must match the oldest queued expectation.
  initial begin
    logic dprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !dprev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done_o rose with no run end expected (cycle_cnt=%0d)", cyc);
        end else begin
          e = sb.pop_front();
          if (pass !== e.ps) begin errors++; $display("FAIL sb_pass: got %b expected %b", pass, e.ps); end
          if (tmo !== e.to) begin errors++; $display("FAIL sb_timeout: got %b expected %b", tmo, e.to); end
          if (exitc !== e.ex) begin errors++; $display("FAIL sb_exit: got %h expected %h", exitc, e.ex); end
          if (ir !== e.ir) begin errors++; $display("FAIL sb_instret: got %0d expected %0d", ir, e.ir); end
          if (cyc !== e.cy) begin errors++; $display("FAIL sb_cycles: got %0d expected %0d", cyc, e.cy); end
        end
      end
      dprev = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic do_restart();
    restart = 1'b1; tick();
    restart = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; restart = 1'b0; pc = '0; retire = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    restart2 = 1'b0; pc2 = '0; retire2 = 1'b1; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    repeat (3) tick();
    checks++;
    if ({core_rst, running, done, pass, tmo} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags: got %b expected 10000", {core_rst, running, done, pass, tmo});
    end
    checks++;
    if (exitc !== 16'h0 || cyc !== 32'd0 || ir !== 32'd0) begin
      errors++; $display("FAIL reset_values: exit=%h cyc=%0d ir=%0d expected all 0", exitc, cyc, ir);
    end
    rst = 1'b0;
    pc = 16'h2; tick();
    checks++;
    if (core_rst !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL rst_edge1: core_rst=%b running=%b expected 1 0", core_rst, running);
    end
    pc = 16'h4; tick();
    checks++;
    if (core_rst !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL rst_edge2: core_rst=%b running=%b expected 0 1", core_rst, running);
    end
    pc = 16'h6; tick();
    checks++;
    if (cyc !== 32'd1) begin errors++; $display("FAIL first_run_cycle: got %0d expected 1", cyc); end
  endtask

  task automatic test_tohost_pass();
    for (int i = 0; i < 10; i++) begin
      pc = pc + 16'd2; retire = 1'b1; tick();
    end
    retire = 1'b0; pc = pc + 16'd2;
    we = 1'b1; addr = 16'hFFFE; wdata = 16'h0001;
    sb.push_back(exp_t'{1'b1, 1'b0, 16'h0001, 32'd10, 32'd12});
    tick();
    we = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL done_freeze: core_rst=%b running=%b expected 1 0", core_rst, running);
    end
    // further events while done must not disturb the result
    for (int i = 0; i < 3; i++) begin
      pc = pc + 16'd2; retire = 1'b1; we = 1'b1; wdata = 16'h0005; tick();
    end
    retire = 1'b0; we = 1'b0;
    checks++;
    if (done !== 1'b1 || exitc !== 16'h0001 || ir !== 32'd10 || cyc !== 32'd12) begin
      errors++; $display("FAIL done_hold: done=%b exit=%h ir=%0d cyc=%0d expected 1 0001 10 12", done, exitc, ir, cyc);
    end
  endtask

  task automatic test_restart();
    restart = 1'b1; tick();
    restart = 1'b0;
    checks++;
    if ({core_rst, running, done, pass, tmo} !== 5'b10000 || exitc !== 16'h0 || cyc !== 32'd0 || ir !== 32'd0) begin
      errors++; $display("FAIL restart_clear: flags=%b exit=%h cyc=%0d ir=%0d expected 10000 0 0 0",
                         {core_rst, running, done, pass, tmo}, exitc, cyc, ir);
    end
    tick();
    checks++;
    if (core_rst !== 1'b1) begin errors++; $display("FAIL restart_rst_hold: got %b expected 1", core_rst); end
    tick();
    checks++;
    if (core_rst !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL restart_run: core_rst=%b running=%b expected 0 1", core_rst, running);
    end
    pc = pc + 16'd2; tick();
    checks++;
    if (cyc !== 32'd1) begin errors++; $display("FAIL restart_count: got %0d expected 1", cyc); end
  endtask

  task automatic test_halt_tie();
    do_restart();
    pc = 16'h0100;
    repeat (4) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL tie_early: done=%b expected 0", done); end
    we = 1'b1; addr = 16'hFFFE; wdata = 16'h0007;
    sb.push_back(exp_t'{1'b0, 1'b0, 16'h0007, 32'd0, 32'd5});
    tick();
    we = 1'b0;
  endtask

  task automatic test_halt();
    do_restart();
    for (int i = 0; i < 5; i++) begin
      pc = 16'h0030 + 16'(2 * i); retire = 1'b1; tick();
    end
    retire = 1'b0; pc = 16'h0040;
    repeat (4) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL halt_early: done=%b expected 0", done); end
    sb.push_back(exp_t'{1'b1, 1'b0, 16'h0000, 32'd5, 32'd10});
    tick();
  endtask

  task automatic test_halt_break();
    do_restart();
    pc = 16'h0050;
    repeat (3) tick();
    pc = 16'h0052;
    repeat (4) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL halt_break: done=%b expected 0", done); end
    sb.push_back(exp_t'{1'b1, 1'b0, 16'h0000, 32'd0, 32'd8});
    tick();
  endtask

  task automatic test_timeout();
    do_restart();
    for (int i = 1; i <= 52; i++) begin
      pc = pc + 16'd2; retire = (i <= 20);
      if (i == 52) sb.push_back(exp_t'{1'b0, 1'b1, 16'h0000, 32'd20, 32'd52});
      tick();
      if (i == 51) begin
        checks++;
        if (done !== 1'b0 || cyc !== 32'd51) begin
          errors++; $display("FAIL timeout_early: done=%b cyc=%0d expected 0 51", done, cyc);
        end
      end
    end
    retire = 1'b0;
    pc = pc + 16'd2; tick();
    checks++;
    if (tmo !== 1'b1 || cyc !== 32'd52) begin
      errors++; $display("FAIL timeout_hold: timeout=%b cyc=%0d expected 1 52", tmo, cyc);
    end
  endtask

  task automatic test_no_timeout();
    restart2 = 1'b1; tick();
    restart2 = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      pc2 = pc2 + 16'd2; tick();
    end
    checks++;
    if ({core_rst2, running2, done2, pass2, tmo2} !== 5'b01000 || exitc2 !== 16'h0) begin
      errors++; $display("FAIL no_timeout_flags: flags=%b exit=%h expected 01000 0",
                         {core_rst2, running2, done2, pass2, tmo2}, exitc2);
    end
    checks++;
    if (cyc2 !== 32'd1098 || ir2 !== 32'd1098) begin
      errors++; $display("FAIL no_timeout_counts: cyc=%0d ir=%0d expected 1098 1098", cyc2, ir2);
    end
  endtask

  task automatic test_async_rst();
    do_restart();
    repeat (3) begin pc = pc + 16'd2; tick(); end
    checks++;
    if (running !== 1'b1 || cyc !== 32'd3) begin
      errors++; $display("FAIL pre_async: running=%b cyc=%0d expected 1 3", running, cyc);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({core_rst, running, done, pass, tmo} !== 5'b10000 || cyc !== 32'd0) begin
      errors++; $display("FAIL async_rst: flags=%b cyc=%0d expected 10000 0", {core_rst, running, done, pass, tmo}, cyc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (core_rst !== 1'b1) begin errors++; $display("FAIL async_seq1: core_rst=%b expected 1", core_rst); end
    tick();
    checks++;
    if (core_rst !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL async_seq2: core_rst=%b running=%b expected 0 1", core_rst, running);
    end
  endtask

  initial begin
    test_reset();
    test_tohost_pass();
    test_restart();
    test_halt_tie();
    test_halt();
    test_halt_break();
    test_timeout();
    test_no_timeout();
    test_async_rst();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d run ends never observed, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_run_monitor.md
Name: riscv_run_monitor

Overview:
- Parametrised, synthesizable run controller for the 16-bit RISC-V core; generalises the fixed bench reset pulse and fixed-time stop.
- Sequences core reset, counts cycles and retired instructions, and ends a run on a tohost write, PC self-loop halt, or cycle timeout.
- Sits beside RISCV_Top: drives its reset and watches its PC, retire and data-memory write buses.
- Usable in simulation and on FPGA.

Parameters:
XLEN, 16, data width of mem_wdata_i and exit_code_o
ADDR_W, 16, width of pc_i and mem_addr_i
RST_CYCLES, 2, cycles core_rst_o is held after reset or restart; must be >= 1
MAX_CYCLES, 52, RUN-cycle budget before timeout; 0 disables timeout
HALT_CYCLES, 4, consecutive unchanged-PC cycles that mean halt; must be >= 1
TOHOST_ADDR, 16'hFFFE, store address that terminates the run
CNT_W, 32, width of the cycle and instret counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
restart_i  input  1  synchronous pulse: clear all state and re-run from S_RST
pc_i  input  ADDR_W  core fetch PC
retire_i  input  1  one instruction retired this cycle
mem_we_i  input  1  core data-memory write strobe
mem_addr_i  input  ADDR_W  core data-memory address
mem_wdata_i  input  XLEN  core data-memory write data
core_rst_o  output  1  reset to core, active-high, registered
running_o  output  1  high while in S_RUN
done_o  output  1  run finished (sticky until rst/restart)
pass_o  output  1  run passed; valid when done_o
timeout_o  output  1  run ended by timeout
exit_code_o  output  XLEN  tohost data, or 0 for halt/timeout
cycle_cnt_o  output  CNT_W  edges spent in S_RUN
instret_cnt_o  output  CNT_W  retired instructions during S_RUN

Behaviour:
- Reset (rst=1, async): state=S_RST, rst_cnt=0, core_rst_o=1, running_o=0, done_o=0, pass_o=0, timeout_o=0, exit_code_o=0, both counters=0, stall_cnt=0, pc_valid=0.
- All outputs are registered; no combinational path from input to output.
- S_RST:
  - core_rst_o=1; rst_cnt increments each edge.
  - At the edge where rst_cnt==RST_CYCLES-1, go to S_RUN; core_rst_o=0 and running_o=1 from that edge on.
  - core_rst_o is therefore high for exactly RST_CYCLES edges after rst deasserts.
- S_RUN, each edge:
  - cycle_cnt += 1; instret_cnt += retire_i.
  - Both counters saturate at all-ones and never wrap.
- Halt detect (S_RUN):
  - pc_q captures pc_i every edge; pc_valid is set on the first RUN edge.
  - If pc_valid && pc_i==pc_q, stall_cnt += 1; otherwise stall_cnt=0.
  - halt_evt occurs when stall_cnt would reach HALT_CYCLES.
- Tohost (S_RUN): tohost_evt = mem_we_i && mem_addr_i==TOHOST_ADDR.
- Timeout (S_RUN): timeout_evt = MAX_CYCLES!=0 && the incremented cycle_cnt == MAX_CYCLES.
- Termination: any event moves to S_DONE at that same edge. Counters include that edge. Priority: tohost > halt > timeout.
  - tohost: exit_code_o=mem_wdata_i; pass_o=(mem_wdata_i==1); timeout_o=0.
  - halt: exit_code_o=0, pass_o=1, timeout_o=0.
  - timeout: exit_code_o=0, pass_o=0, timeout_o=1.
  - Latency: an event sampled at edge k gives done_o=1 after edge k.
- S_DONE:
  - core_rst_o=1 (freezes core), running_o=0.
  - Counters, flags and exit code are held; further events are ignored.
- restart_i:
  - In any state, takes priority over events.
  - Next edge: same values as rst except asynchronous behaviour (state=S_RST, core_rst_o=1, all flags/counters/exit code cleared).
- rst mid-run: immediate asynchronous return to the reset values; sequence restarts when rst falls.
- retire_i, mem_we_i and pc_i are ignored outside S_RUN.

Test Plan:
- Reset release, defaults: rst high 3 cycles, then low → core_rst_o high exactly 2 edges, then 0; running_o=1; cycle_cnt_o=1 after first RUN edge.
- Tohost pass: in RUN, retire_i every cycle for 10 cycles, then write addr 16'hFFFE data 16'h0001 → done_o=1, pass_o=1, exit_code_o=1, instret_cnt_o=10, core_rst_o=1 next edge.
- Tohost fail with simultaneous halt: write 16'h0007 to TOHOST_ADDR on the same edge halt_evt fires → pass_o=0, exit_code_o=7, timeout_o=0 (tohost wins).
- PC halt: PC increments by 2, then holds 16'h0040 → done_o rises on the 4th consecutive equal-PC edge, pass_o=1, exit_code_o=0; a PC change on the 3rd equal edge resets stall_cnt and no halt occurs.
- Timeout: PC always changing, no tohost → done_o and timeout_o rise at the edge cycle_cnt_o becomes 52, pass_o=0; with MAX_CYCLES=0, no termination after 1000 cycles.
- Restart and async reset: restart_i in S_DONE → all outputs cleared, core_rst_o held 2 edges, new run counts from 0. rst pulse mid-RUN between edges → outputs reset immediately, without waiting for a clock edge.
